axi_lite_mem_bridge: RTL and testbench

AXI_LITE_MEM_BRIDGE -- requirements
Module: axi_lite_mem_bridge

---
 rtl/ariane_axi.sv | 52 +++++
 rtl/axi_lite_mem_bridge_pkg.sv | 12 +
 rtl/axi_lite_mem_bridge_arb.sv | 24 ++
 rtl/axi_lite_mem_bridge.sv | 196 +++++++++++++++++++
 tb/tb_axi_lite_mem_bridge.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/ariane_axi.sv
// Minimal AXI request/response structs used as the default bridge types.
// Only the fields an AXI4-Lite slave consumes or drives are modelled.
package ariane_axi;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned IdWidth   = 10;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
  } ax_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

// File: rtl/axi_lite_mem_bridge_pkg.sv
// Shared FSM encodings, response codes and latency limits for the
// AXI4-Lite to memory-port bridge.
package axi_lite_mem_bridge_pkg;
  localparam int unsigned MAX_RD_LATENCY = 4;
  localparam int unsigned LAT_CNT_W      = $clog2(MAX_RD_LATENCY + 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} r_state_e;
endpackage

// File: rtl/axi_lite_mem_bridge_arb.sv
// Two-requester round-robin arbiter; write wins the first contention after
// reset and priority flips only when both requesters collide.
module axi_lite_mem_bridge_arb (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_w_i,
  input  logic req_r_i,
  output logic gnt_w_o,
  output logic gnt_r_o
);
  logic rd_prio_q, rd_prio_d;

  always_comb begin
    gnt_w_o   = req_w_i && !(req_r_i && rd_prio_q);
    gnt_r_o   = req_r_i && !(req_w_i && !rd_prio_q);
    rd_prio_d = rd_prio_q;
    if (req_w_i && req_r_i) rd_prio_d = !rd_prio_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rd_prio_q <= 1'b0;
    else       rd_prio_q <= rd_prio_d;
  end
endmodule

// File: rtl/axi_lite_mem_bridge.sv
// AXI4-Lite slave bridged onto a single memory-like port with independent
// read/write FSMs. Define AXI_LITE_MEM_BRIDGE_RANGE_CHECK_EN to SLVERR accesses
// outside [ADDR_BASE, ADDR_BASE+ADDR_SIZE) without touching memory.
module axi_lite_mem_bridge
  import axi_lite_mem_bridge_pkg::*;
#(
  parameter int unsigned               AXI_ADDR_WIDTH = 64,
  parameter int unsigned               AXI_DATA_WIDTH = 64,
  parameter int unsigned               AXI_ID_WIDTH   = 10,
  parameter int unsigned               RD_LATENCY     = 1,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_BASE      = '0,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_SIZE      = 'h1000,
  parameter type                       axi_req_t      = ariane_axi::req_t,
  parameter type                       axi_resp_t     = ariane_axi::resp_t
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  axi_req_t                    axi_req_i,
  output axi_resp_t                   axi_resp_o,
  output logic [AXI_ADDR_WIDTH-1:0]   address_o,
  output logic                        en_o,
  output logic                        we_o,
  output logic [AXI_DATA_WIDTH/8-1:0] be_o,
  output logic [AXI_DATA_WIDTH-1:0]   data_o,
  input  logic [AXI_DATA_WIDTH-1:0]   data_i
);
  localparam logic [LAT_CNT_W-1:0] RD_LAT_CNT = LAT_CNT_W'(RD_LATENCY);

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
  logic [AXI_ID_WIDTH-1:0]     aw_id_q, aw_id_d, ar_id_q, ar_id_d;
  logic [AXI_DATA_WIDTH-1:0]   w_data_q, w_data_d, rdata_q, rdata_d;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb_q, w_strb_d;
  logic [LAT_CNT_W-1:0]        rd_cnt_q, rd_cnt_d;

  logic run, aw_rdy, w_rdy, ar_rdy, aw_hs, w_hs, ar_hs;
  logic w_err, r_err, req_w, req_r, gnt_w, gnt_r;

  // Handshakes and grants are masked while reset is held so nothing leaks out.
  assign run    = !rst_i;
  assign aw_rdy = run && (w_state_q == W_IDLE) && !aw_got_q;
  assign w_rdy  = run && (w_state_q == W_IDLE) && !w_got_q;
  assign ar_rdy = run && (r_state_q == R_IDLE);
  assign aw_hs  = aw_rdy && axi_req_i.aw_valid;
  assign w_hs   = w_rdy && axi_req_i.w_valid;
  assign ar_hs  = ar_rdy && axi_req_i.ar_valid;

`ifdef AXI_LITE_MEM_BRIDGE_RANGE_CHECK_EN
  function automatic logic out_of_window(input logic [AXI_ADDR_WIDTH-1:0] a);
    return (a < ADDR_BASE) || ((a - ADDR_BASE) >= ADDR_SIZE);
  endfunction
  assign w_err = out_of_window(aw_addr_q);
  assign r_err = out_of_window(ar_addr_q);
`else
  assign w_err = 1'b0;
  assign r_err = 1'b0;
`endif

  assign req_w = run && (w_state_q == W_ISSUE) && !w_err;
  assign req_r = run && (r_state_q == R_ISSUE) && !r_err;

  axi_lite_mem_bridge_arb u_arb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_w_i(req_w),
    .req_r_i(req_r),
    .gnt_w_o(gnt_w),
    .gnt_r_o(gnt_r)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      aw_addr_q <= '0;
      aw_id_q   <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_addr_q <= '0;
      ar_id_q   <= '0;
      rd_cnt_q  <= '0;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      aw_addr_q <= aw_addr_d;
      aw_id_q   <= aw_id_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      ar_addr_q <= ar_addr_d;
      ar_id_q   <= ar_id_d;
      rd_cnt_q  <= rd_cnt_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE:  if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) w_state_d = W_ISSUE;
      W_ISSUE: if (w_err || gnt_w) w_state_d = W_RESP;
      W_RESP:  if (axi_req_i.b_ready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase

    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_ISSUE;
      R_ISSUE: if (r_err) r_state_d = R_RESP;
               else if (gnt_r) r_state_d = R_WAIT;
      R_WAIT:  if (rd_cnt_q == RD_LAT_CNT) r_state_d = R_RESP;
      R_RESP:  if (axi_req_i.r_ready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    aw_addr_d = aw_addr_q;
    aw_id_d   = aw_id_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    ar_addr_d = ar_addr_q;
    ar_id_d   = ar_id_q;
    rd_cnt_d  = rd_cnt_q;
    rdata_d   = rdata_q;
    if (aw_hs) begin
      aw_got_d  = 1'b1;
      aw_addr_d = axi_req_i.aw.addr;
      aw_id_d   = axi_req_i.aw.id;
    end
    if (w_hs) begin
      w_got_d  = 1'b1;
      w_data_d = axi_req_i.w.data;
      w_strb_d = axi_req_i.w.strb;
    end
    if ((w_state_q == W_RESP) && axi_req_i.b_ready) begin
      aw_got_d = 1'b0;
      w_got_d  = 1'b0;
    end
    if (ar_hs) begin
      ar_addr_d = axi_req_i.ar.addr;
      ar_id_d   = axi_req_i.ar.id;
    end
    // Counter reads 1 in the first wait cycle, so equality marks data_i valid.
    if (gnt_r) rd_cnt_d = LAT_CNT_W'(1);
    else if (r_state_q == R_WAIT) rd_cnt_d = rd_cnt_q + 1'b1;
    if ((r_state_q == R_WAIT) && (rd_cnt_q == RD_LAT_CNT)) rdata_d = data_i;
    if ((r_state_q == R_ISSUE) && r_err) rdata_d = '0;
  end

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = aw_rdy;
    axi_resp_o.w_ready  = w_rdy;
    axi_resp_o.ar_ready = ar_rdy;
    axi_resp_o.b_valid  = run && (w_state_q == W_RESP);
    axi_resp_o.b.id     = aw_id_q;
    axi_resp_o.b.resp   = w_err ? RESP_SLVERR : RESP_OKAY;
    axi_resp_o.r_valid  = run && (r_state_q == R_RESP);
    axi_resp_o.r.id     = ar_id_q;
    axi_resp_o.r.data   = rdata_q;
    axi_resp_o.r.resp   = r_err ? RESP_SLVERR : RESP_OKAY;
    axi_resp_o.r.last   = 1'b1;

    en_o      = gnt_w || gnt_r;
    we_o      = gnt_w;
    address_o = '0;
    be_o      = '0;
    data_o    = '0;
    if (gnt_w) begin
      address_o = aw_addr_q;
      be_o      = w_strb_q;
      data_o    = w_data_q;
    end else if (gnt_r) begin
      address_o = ar_addr_q;
    end
  end

`ifndef SYNTHESIS
  a_ar_len: assert property (@(posedge clk_i) disable iff (rst_i)
    axi_req_i.ar_valid |-> axi_req_i.ar.len == '0);
  a_aw_len: assert property (@(posedge clk_i) disable iff (rst_i)
    axi_req_i.aw_valid |-> axi_req_i.aw.len == '0);
  a_rd_lat: assert property (@(posedge clk_i)
    (RD_LATENCY >= 1) && (RD_LATENCY <= MAX_RD_LATENCY));
  a_window: assert property (@(posedge clk_i) ADDR_BASE + ADDR_SIZE > ADDR_BASE);
`endif
endmodule

// File: tb/tb_axi_lite_mem_bridge.sv
// Randomized and directed bench for axi_lite_mem_bridge against a shadow-memory
// model; honours AXI_LITE_MEM_BRIDGE_RANGE_CHECK_EN for expected responses.
module tb_axi_lite_mem_bridge;
  localparam int unsigned LAT  = 3;
  localparam logic [63:0] BASE = 64'h0;
  localparam logic [63:0] SIZE = 64'h1000;

  logic clk = 1'b0;
  logic rst;
  ariane_axi::req_t  req;
  ariane_axi::resp_t resp;
  logic [63:0] address, wdata, rdata;
  logic        en, we;
  logic [7:0]  be;

  always #5 clk = ~clk;

  axi_lite_mem_bridge #(
    .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10),
    .RD_LATENCY(LAT), .ADDR_BASE(BASE), .ADDR_SIZE(SIZE)
  ) dut (
    .clk_i(clk), .rst_i(rst), .axi_req_i(req), .axi_resp_o(resp),
    .address_o(address), .en_o(en), .we_o(we), .be_o(be),
    .data_o(wdata), .data_i(rdata)
  );

  // Memory environment: 64 words, read data appears LAT cycles after issue.
  logic [63:0] mem [64];
  logic [63:0] rd_pipe [LAT];
  logic [63:0] exp_mem [64];
  logic [63:0] last_addr, last_data;
  logic        last_we;
  logic        init_mem;
  int          en_cnt = 0;
  int          n_chk = 0, n_err = 0;

  function automatic logic [63:0] init_word(input int i);
    return 64'hC0DE_0000_0000_0000 ^ (64'(i) * 64'h0001_0203_0405_0607);
  endfunction

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (en && we) begin
      for (int b = 0; b < 8; b++)
        if (be[b]) mem[address[8:3]][8*b +: 8] <= wdata[8*b +: 8];
    end
    rd_pipe[0] <= (en && !we) ? mem[address[8:3]] : {$urandom, $urandom};
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    if (en) begin
      en_cnt    <= en_cnt + 1;
      last_addr <= address;
      last_data <= wdata;
      last_we   <= we;
    end
  end
  assign rdata = rd_pipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic [63:0] a);
    bit oob;
    oob = (a < BASE) || (a >= BASE + SIZE);
`ifndef AXI_LITE_MEM_BRIDGE_RANGE_CHECK_EN
    oob = 1'b0;
`endif
    return oob ? 2'b10 : 2'b00;
  endfunction

  task automatic axi_wr(input logic [63:0] a, input logic [9:0] id, input logic [63:0] d,
                        input logic [7:0] s, input int aw_dly, input int w_dly, input int b_dly);
    int t, k, en0;
    bit aw_done, w_done, hs_aw, hs_w;
    logic [1:0] er;
    er = exp_resp(a); en0 = en_cnt; t = 0; aw_done = 0; w_done = 0;
    req.aw.addr = a; req.aw.id = id; req.aw.len = '0; req.w.data = d; req.w.strb = s;
    while (!(aw_done && w_done) && t < 40) begin
      req.aw_valid = !aw_done && (t >= aw_dly);
      req.w_valid  = !w_done && (t >= w_dly);
      hs_aw = req.aw_valid && resp.aw_ready;
      hs_w  = req.w_valid && resp.w_ready;
      @(negedge clk); t++;
      aw_done = aw_done | hs_aw;
      w_done  = w_done | hs_w;
    end
    req.aw_valid = 0; req.w_valid = 0;
    chk("wr_accept", {62'b0, aw_done, w_done}, 64'h3);
    k = 1;
    while (!resp.b_valid && k < 40) begin @(negedge clk); k++; end
    chk("wr_lat", 64'(k), 64'd2);
    chk("wr_bid", 64'(resp.b.id), 64'(id));
    chk("wr_bresp", 64'(resp.b.resp), 64'(er));
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      chk("wr_bhold", 64'({resp.b_valid, resp.b.id}), 64'({1'b1, id}));
    end
    req.b_ready = 1; @(negedge clk); req.b_ready = 0;
    chk("wr_bdone", 64'(resp.b_valid), 64'd0);
    chk("wr_en_cnt", 64'(en_cnt - en0), (er == 2'b00) ? 64'd1 : 64'd0);
    if (er == 2'b00)
      for (int b = 0; b < 8; b++) if (s[b]) exp_mem[a[8:3]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic axi_rd(input logic [63:0] a, input logic [9:0] id, input int r_dly);
    int k, en0;
    logic [1:0]  er;
    logic [63:0] ed;
    er = exp_resp(a); en0 = en_cnt;
    ed = (er == 2'b00) ? exp_mem[a[8:3]] : 64'h0;
    req.ar.addr = a; req.ar.id = id; req.ar.len = '0; req.ar_valid = 1;
    k = 0;
    while (!resp.ar_ready && k < 40) begin @(negedge clk); k++; end
    @(negedge clk); req.ar_valid = 0;
    k = 1;
    while (!resp.r_valid && k < 40) begin @(negedge clk); k++; end
    chk("rd_lat", 64'(k), (er == 2'b00) ? 64'(LAT + 2) : 64'd2);
    chk("rd_data", resp.r.data, ed);
    chk("rd_id", 64'(resp.r.id), 64'(id));
    chk("rd_resp", 64'(resp.r.resp), 64'(er));
    chk("rd_last", 64'(resp.r.last), 64'd1);
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clk);
      chk("rd_hold", resp.r_valid ? resp.r.data : ~ed, ed);
    end
    req.r_ready = 1; @(negedge clk); req.r_ready = 0;
    chk("rd_done", 64'(resp.r_valid), 64'd0);
    chk("rd_en_cnt", 64'(en_cnt - en0), (er == 2'b00) ? 64'd1 : 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, k, en0;
    bit b_seen, r_seen;
    logic [63:0] a, d;
    req = '0; rst = 1; init_mem = 1;
    for (int i = 0; i < 64; i++) exp_mem[i] = init_word(i);
    @(negedge clk);
    chk("rst_aw_ready", 64'(resp.aw_ready), 64'd0);
    chk("rst_en", 64'(en), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 0; init_mem = 0;
    @(negedge clk);
    chk("idle_ready", 64'({resp.aw_ready, resp.w_ready, resp.ar_ready}), 64'h7);
    chk("idle_valid", 64'({resp.b_valid, resp.r_valid}), 64'h0);
    chk("idle_port", {63'b0, en} | address | wdata | 64'(be), 64'h0);

    // Write and read collide twice: write wins first, read wins second.
    for (int rep = 0; rep < 2; rep++) begin
      d = {$urandom, $urandom};
      req.aw.addr = 64'h40; req.aw.id = 10'd1; req.w.data = d; req.w.strb = 8'hFF;
      req.ar.addr = 64'h48; req.ar.id = 10'd2;
      req.aw_valid = 1; req.w_valid = 1; req.ar_valid = 1;
      @(negedge clk);
      req.aw_valid = 0; req.w_valid = 0; req.ar_valid = 0;
      chk("arb_first", 64'({en, we}), (rep == 0) ? 64'h3 : 64'h2);
      @(negedge clk);
      chk("arb_second", 64'({en, we}), (rep == 0) ? 64'h2 : 64'h3);
      req.b_ready = 1; req.r_ready = 1;
      b_seen = 0; r_seen = 0; k = 0;
      while (!(b_seen && r_seen) && k < 20) begin
        if (resp.b_valid) b_seen = 1;
        if (resp.r_valid) begin r_seen = 1; chk("arb_rdata", resp.r.data, exp_mem[9]); end
        @(negedge clk); k++;
      end
      req.b_ready = 0; req.r_ready = 0;
      chk("arb_done", 64'({b_seen, r_seen}), 64'h3);
      exp_mem[8] = d;
    end

    axi_wr(64'h10, 10'd3, 64'hDEAD, 8'hFF, 0, 2, 0);
    chk("w29_addr", last_addr, 64'h10);
    chk("w29_data", last_data, 64'hDEAD);
    chk("w29_we", 64'(last_we), 64'd1);
    axi_wr(64'h18, 10'd5, 64'h1122_3344_5566_7788, 8'h0F, 0, 0, 5);
    axi_wr(64'h28, 10'd6, 64'hFFFF_FFFF_FFFF_FFFF, 8'h5A, 3, 0, 0);
    axi_wr(64'h20, 10'd6, 64'h1234, 8'hFF, 0, 0, 0);
    axi_rd(64'h20, 10'd7, 4);
    axi_rd(64'h18, 10'd8, 0);
    axi_rd(64'h28, 10'd9, 1);
    axi_rd(BASE + SIZE, 10'd11, 1);
    axi_wr(BASE + SIZE + 64'h8, 10'd12, 64'hBAD0_BAD0, 8'hFF, 1, 0, 0);
    axi_rd(64'h8, 10'd13, 0);

    // Reset while a read sits in its wait state must leave no trace.
    req.ar.addr = 64'h30; req.ar.id = 10'd4; req.ar_valid = 1;
    @(negedge clk);
    req.ar_valid = 0;
    chk("rst34_issue", 64'(en), 64'd1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    en0 = en_cnt;
    chk("rst34_rvalid", 64'({resp.r_valid, en}), 64'd0);
    rst = 0;
    @(negedge clk);
    chk("rst34_ar_ready", 64'(resp.ar_ready), 64'd1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (resp.r_valid || en) bad++;
      @(negedge clk);
    end
    chk("rst34_stale", 64'(bad), 64'd0);
    chk("rst34_no_access", 64'(en_cnt - en0), 64'd0);

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 7) == 0) a = BASE + SIZE + (64'($urandom_range(0, 7)) << 3);
      else a = 64'($urandom_range(0, 63)) << 3;
      if ($urandom_range(0, 1) == 0)
        axi_wr(a, 10'($urandom), {$urandom, $urandom}, 8'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_rd(a, 10'($urandom), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
